// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port, byte-addressed data memory between the CPU MEM
//   stage and a debug/loader port. Each access is sequenced over a memory
//   with fixed latency: IDLE (grant) -> ACCESS (MEM_LAT cycles) -> RESP.
//   The CPU pipeline stays stalled until its own access reaches RESP.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   cpu_req_i/we/addr/wdata    CPU request, held until served
//   cpu_rdata_o                CPU read data, valid in its RESP cycle, held
//   cpu_stall_o                combinational pipeline freeze
//   dbg_req_i/we/addr/wdata    debug request, held until dbg_ack_o
//   dbg_rdata_o, dbg_ack_o     debug read data and one-cycle completion pulse
//   mem_en_o/we/addr/wdata     memory command (registered)
//   mem_rdata_i                memory read data
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_owner_dbg;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [SC_W-1:0]     r_starve_cnt;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_dbg_rdata;
    logic                r_dbg_ack;

    logic                w_grant_dbg;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    // Debug only beats a pending CPU request once it has been passed over
    // STARVE_MAX times in a row.
    assign w_grant_dbg = dbg_req_i &
                         (~cpu_req_i | (r_starve_cnt == SC_W'(STARVE_MAX)));
    assign w_sel_we    = w_grant_dbg ? dbg_we_i    : cpu_we_i;
    assign w_sel_addr  = w_grant_dbg ? dbg_addr_i  : cpu_addr_i;
    assign w_sel_wdata = w_grant_dbg ? dbg_wdata_i : cpu_wdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_owner_dbg  <= 1'b0;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
            r_dbg_ack    <= 1'b0;
        end else begin
            r_dbg_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req_i || dbg_req_i) begin
                        r_owner_dbg <= w_grant_dbg;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_sel_we;
                        // Unaligned addresses are silently word-aligned.
                        r_mem_addr  <= w_sel_addr & ALIGN_MASK;
                        r_mem_wdata <= w_sel_wdata;
                        r_lat_cnt   <= LAT_W'(MEM_LAT - 1);
                        r_state     <= S_ACCESS;
                    end
                    // A waiting debug request that loses to the CPU ages the
                    // counter; no debug request or a debug win resets it.
                    if (!dbg_req_i || w_grant_dbg) begin
                        r_starve_cnt <= '0;
                    end else if (r_starve_cnt != SC_W'(STARVE_MAX)) begin
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (r_lat_cnt == '0) begin
                        if (!r_mem_we) begin
                            if (r_owner_dbg) begin
                                r_dbg_rdata <= mem_rdata_i;
                            end else begin
                                r_cpu_rdata <= mem_rdata_i;
                            end
                        end
                        r_mem_en  <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_dbg_ack <= r_owner_dbg;
                        r_state   <= S_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall every cycle the CPU waits, releasing only in its own RESP cycle.
    assign cpu_stall_o = ~rst_i & cpu_req_i &
                         ~((r_state == S_RESP) & ~r_owner_dbg);

    assign cpu_rdata_o = r_cpu_rdata;
    assign dbg_rdata_o = r_dbg_rdata;
    assign dbg_ack_o   = r_dbg_ack;
    assign mem_en_o    = r_mem_en;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
    logic [4:0]  cpu_addr_i = '0;
    logic [31:0] cpu_wdata_i = '0;
    logic [31:0] cpu_rdata_o;
    logic        cpu_stall_o;
    logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
    logic [4:0]  dbg_addr_i = '0;
    logic [31:0] dbg_wdata_i = '0;
    logic [31:0] dbg_rdata_o;
    logic        dbg_ack_o;
    logic        mem_en_o, mem_we_o;
    logic [4:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Memory model: data appears one enabled cycle after the address.
    logic [31:0] mem [8];
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) mem[mem_addr_o[4:2]] <= mem_wdata_o;
            mem_rdata_i <= mem[mem_addr_o[4:2]];
        end
    end

    typedef struct packed {
        logic        is_dbg;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acks   = 0;
    int          exp_acks = 0;
    logic [31:0] model_mem [8];
    logic [31:0] exp_cpu_rdata = '0;
    logic [31:0] exp_dbg_rdata = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected response for a transaction, in the order it must complete.
    task automatic push_exp(input logic is_dbg, input logic we, input logic [4:0] addr,
                            input logic [31:0] wdata);
        exp_t e;
        logic [2:0] idx;
        idx = addr[4:2];
        if (we) begin
            model_mem[idx] = wdata;
        end else if (is_dbg) begin
            exp_dbg_rdata = model_mem[idx];
        end else begin
            exp_cpu_rdata = model_mem[idx];
        end
        e.is_dbg = is_dbg;
        e.rdata  = is_dbg ? exp_dbg_rdata : exp_cpu_rdata;
        sb_q.push_back(e);
        if (is_dbg) exp_acks++;
    endtask

    task automatic sb_pop(input logic is_dbg, input logic [31:0] rdata);
        exp_t        e;
        logic [31:0] exp_owner;
        e = '0;
        exp_owner = 32'd3;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            exp_owner = {31'd0, e.is_dbg};
        end
        check_eq("owner", {31'd0, is_dbg}, exp_owner);
        check_eq(is_dbg ? "dbg_rdata" : "cpu_rdata", rdata, e.rdata);
        $display("txn %s done rdata=%h expected=%h", is_dbg ? "DBG" : "CPU", rdata, e.rdata);
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            if (cpu_req_i && !cpu_stall_o) sb_pop(1'b0, cpu_rdata_o);
            if (dbg_ack_o) begin
                n_acks++;
                sb_pop(1'b1, dbg_rdata_o);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that ends RESP.
    task automatic cpu_drive(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                             output int stall_cyc, output int we_cyc, output logic [4:0] seen_addr);
        bit done;
        done      = 1'b0;
        stall_cyc = 0;
        we_cyc    = 0;
        seen_addr = '0;
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (mem_en_o && mem_we_o) we_cyc++;
            if (mem_en_o) seen_addr = mem_addr_o;
            if (cpu_stall_o) stall_cyc++;
            else done = 1'b1;
        end
        check_eq("cpu_complete", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_drive(input logic we, input logic [4:0] addr, input logic [31:0] wdata);
        bit done;
        done        = 1'b0;
        dbg_req_i   = 1'b1;
        dbg_we_i    = we;
        dbg_addr_i  = addr;
        dbg_wdata_i = wdata;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (dbg_ack_o) done = 1'b1;
        end
        check_eq("dbg_complete", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        dbg_req_i = 1'b0;
    endtask

    task automatic cpu_seq(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                           input int exp_stall);
        int s, w;
        logic [4:0] a;
        push_exp(1'b0, we, addr, wdata);
        cpu_drive(we, addr, wdata, s, w, a);
        cpu_req_i = 1'b0;
        check_eq("cpu_stall_cycles", s, exp_stall);
    endtask

    task automatic dbg_seq(input logic we, input logic [4:0] addr, input logic [31:0] wdata);
        push_exp(1'b1, we, addr, wdata);
        dbg_drive(we, addr, wdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s3, w3, s4, w4, s6, w6, ack_snap;
        logic [4:0]  a3, a4, a6;
        logic [4:0]  t4_addr [5];
        t4_addr = '{5'h08, 5'h0C, 5'h10, 5'h14, 5'h18};

        // Reset state, with a CPU request present to show stall is gated.
        repeat (2) @(posedge clk);
        #1 cpu_req_i = 1'b1;
        @(negedge clk);
        check_eq("rst_stall", {31'd0, cpu_stall_o}, 32'd0);
        check_eq("rst_mem_en", {31'd0, mem_en_o}, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        check_eq("rst_mem_addr", {27'd0, mem_addr_o}, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata_o, 32'd0);
        check_eq("rst_cpu_rdata", cpu_rdata_o, 32'd0);
        check_eq("rst_dbg_rdata", dbg_rdata_o, 32'd0);
        check_eq("rst_dbg_ack", {31'd0, dbg_ack_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        cpu_req_i = 1'b0;

        // Preload through the debug port.
        dbg_seq(1'b1, 5'h00, 32'd5);
        for (int k = 2; k < 7; k++) dbg_seq(1'b1, 5'(k * 4), 32'h1000 + k);

        // Lone CPU read: stalled IDLE + 2 ACCESS cycles.
        cpu_seq(1'b0, 5'h00, 32'd0, 3);

        // Debug write then CPU read of the same word.
        dbg_seq(1'b1, 5'h04, 32'hDEADBEEF);
        cpu_seq(1'b0, 5'h04, 32'd0, 3);

        // Simultaneous requests with no starvation history: CPU first.
        push_exp(1'b0, 1'b0, 5'h00, 32'd0);
        push_exp(1'b1, 1'b0, 5'h04, 32'd0);
        fork
            begin
                cpu_drive(1'b0, 5'h00, 32'd0, s3, w3, a3);
                cpu_req_i = 1'b0;
            end
            dbg_drive(1'b0, 5'h04, 32'd0);
        join
        check_eq("t3_cpu_stall_cycles", s3, 32'd3);

        // Continuous CPU traffic: four CPU grants, then debug, then CPU.
        for (int k = 0; k < 4; k++) push_exp(1'b0, 1'b0, t4_addr[k], 32'd0);
        push_exp(1'b1, 1'b1, 5'h1C, 32'hA5A50001);
        push_exp(1'b0, 1'b0, t4_addr[4], 32'd0);
        s4 = 0;
        fork
            begin
                for (int k = 0; k < 5; k++) cpu_drive(1'b0, t4_addr[k], 32'd0, s4, w4, a4);
                cpu_req_i = 1'b0;
            end
            dbg_drive(1'b1, 5'h1C, 32'hA5A50001);
        join
        // Last CPU access waited through the whole debug access.
        check_eq("t4_cpu5_stall_cycles", s4, 32'd7);
        dbg_seq(1'b0, 5'h1C, 32'd0);

        // Reset during the first ACCESS cycle of a debug read.
        dbg_req_i  = 1'b1;
        dbg_we_i   = 1'b0;
        dbg_addr_i = 5'h10;
        @(posedge clk);
        #1;
        rst_i     = 1'b1;
        cpu_req_i = 1'b1;
        @(negedge clk);
        check_eq("t5_en_in_access", {31'd0, mem_en_o}, 32'd1);
        check_eq("t5_stall_in_rst", {31'd0, cpu_stall_o}, 32'd0);
        @(negedge clk);
        check_eq("t5_en_after_rst", {31'd0, mem_en_o}, 32'd0);
        check_eq("t5_ack_after_rst", {31'd0, dbg_ack_o}, 32'd0);
        check_eq("t5_cpu_rdata_rst", cpu_rdata_o, 32'd0);
        check_eq("t5_dbg_rdata_rst", dbg_rdata_o, 32'd0);
        exp_cpu_rdata = '0;
        exp_dbg_rdata = '0;
        ack_snap = n_acks;
        @(posedge clk);
        #1;
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        dbg_req_i = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("t5_no_ack", n_acks, ack_snap);
        @(posedge clk);
        #1;

        // Unaligned CPU write is aligned; FSM back in IDLE (stall of 3).
        push_exp(1'b0, 1'b1, 5'h07, 32'd9);
        cpu_drive(1'b1, 5'h07, 32'd9, s6, w6, a6);
        cpu_req_i = 1'b0;
        check_eq("t6_stall_cycles", s6, 32'd3);
        check_eq("t6_we_cycles", w6, 32'd2);
        check_eq("t6_mem_addr", {27'd0, a6}, 32'h04);
        cpu_seq(1'b0, 5'h04, 32'd0, 3);

        repeat (3) @(negedge clk);
        check_eq("sb_leftover", sb_q.size(), 32'd0);
        check_eq("dbg_ack_count", n_acks, exp_acks);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
